// File: rtl/mem_arbiter_pkg.sv
// Shared cache/memory request and response types, plus the arbiter state
// encoding used by mem_arbiter.
package cache_definition;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 32;
    localparam int ARB_PORTS = 2;

    typedef struct packed {
        logic              valid;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cache_to_mem_type;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
    } mem_to_cache_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_type;

    // Watchdog counter width: enough to hold TIMEOUT_CYCLES-1, never below 1 bit.
    function automatic int wd_cnt_width(input int timeout_cycles);
        int w;
        w = (timeout_cycles <= 0) ? 1 : $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between two caches.
// The owner's request is passed straight through, the controller response is
// routed back to the owner only, and a watchdog releases a grant whose
// response never arrives.
module mem_arbiter
    import cache_definition::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  cache_to_mem_type     req0,
    output mem_to_cache_type     rsp0,
    input  cache_to_mem_type     req1,
    output mem_to_cache_type     rsp1,
    output cache_to_mem_type     mem_req,
    input  mem_to_cache_type     mem_rsp,
    output logic [ARB_PORTS-1:0] grant,
    output logic                 timeout_err
);

    localparam int             CNT_W    = wd_cnt_width(TIMEOUT_CYCLES);
    localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_type    state;
    arb_state_type    state_nxt;
    logic             prio;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_fire;
    logic             own_start;
    logic             own_end;

    // Grant is a direct decode of the owner state, so it drops the moment
    // reset forces the state back to IDLE.
    assign grant     = {state == OWN1, state == OWN0};
    assign own_start = (state == IDLE) && (state_nxt != IDLE);
    assign own_end   = (state != IDLE) && (state_nxt == IDLE);

    // Next-state selection plus request mux and response demux by owner.
    always_comb begin
        state_nxt = state;
        mem_req   = '0;
        rsp0      = '0;
        rsp1      = '0;
        wd_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0.valid && req1.valid) begin
                    state_nxt = prio ? OWN1 : OWN0;
                end else if (req0.valid) begin
                    state_nxt = OWN0;
                end else if (req1.valid) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                mem_req = req0;
                rsp0    = mem_rsp;
                if (mem_rsp.ready) begin
                    state_nxt = IDLE;
                end else if (WD_EN && (wd_cnt == '0)) begin
                    // Fake a completion with zero data so the cache unblocks.
                    wd_fire    = 1'b1;
                    rsp0.ready = 1'b1;
                    rsp0.data  = '0;
                    state_nxt  = IDLE;
                end
            end
            OWN1: begin
                mem_req = req1;
                rsp1    = mem_rsp;
                if (mem_rsp.ready) begin
                    state_nxt = IDLE;
                end else if (WD_EN && (wd_cnt == '0)) begin
                    wd_fire    = 1'b1;
                    rsp1.ready = 1'b1;
                    rsp1.data  = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner state, round-robin preference, watchdog countdown and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;

            if (own_start) begin
                wd_cnt <= CNT_LOAD;
            end else if (own_end) begin
                wd_cnt <= '0;
            end else if ((state != IDLE) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - CNT_W'(1);
            end

            // The port that just finished yields preference to the other one.
            if (own_end) begin
                prio <= (state == OWN0);
            end

            if (wd_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `sram_controller` memory port between two cache requesters (e.g. instruction and data cache). It sits between the caches and the SRAM controller, grants one request at a time with round-robin fairness, and routes the controller's response back to the granted requester only. It also runs a watchdog so a cache can never hang on a lost response.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: granted cycles allowed before watchdog fires; 0 disables watchdog.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0`  in  `cache_to_mem_type`  request from requester 0 (valid, rw, addr, data).
- `rsp0`  out  `mem_to_cache_type`  response to requester 0 (ready, data).
- `req1`  in  `cache_to_mem_type`  request from requester 1.
- `rsp1`  out  `mem_to_cache_type`  response to requester 1.
- `mem_req`  out  `cache_to_mem_type`  request to SRAM controller.
- `mem_rsp`  in  `mem_to_cache_type`  response from SRAM controller.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `timeout_err`  out  1  sticky watchdog flag, cleared only by `rst`.

## Operation
- States: IDLE, OWN0, OWN1. Register `prio` (1 bit) names the preferred port.
- IDLE: only one valid -> go to that port's OWN state. Both valid -> go to OWN[`prio`]. Neither valid -> stay in IDLE.
- OWNx: `mem_req` = `reqx` (all fields, live pass-through). `rspx.ready` = `mem_rsp.ready`, `rspx.data` = `mem_rsp.data`. Non-owner response: ready=0, data=0.
- IDLE: `mem_req.valid`=0, other `mem_req` fields=0, both rsp.ready=0.
- OWNx -> IDLE on `mem_rsp.ready`=1. On that edge `prio` <= the other port.
- Grant is locked until completion. If the owner drops `valid` early, that is a protocol violation. The arbiter keeps the grant and forwards valid=0, and does not abort.
- Watchdog: counter loaded with `TIMEOUT_CYCLES-1` on entry to OWNx; decrements each OWN cycle. If the counter is 0 and `mem_rsp.ready`=0 (and TIMEOUT_CYCLES≠0):
  - pulse `rspx.ready`=1 with data=0 for one cycle;
  - set `timeout_err`;
  - go to IDLE and flip `prio`.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

## Timing
- Reset values: state IDLE, `prio`=0, `grant`=00, `timeout_err`=0, counter=0, `mem_req.valid`=0, `rsp0.ready`=`rsp1.ready`=0.
- Arbitration latency: 1 cycle. A valid sampled in IDLE at edge N gives `mem_req.valid`=1 and `grant` set from cycle N+1.
- Response path is combinational, with 0 added latency: `rspx.ready` is asserted in the same cycle as `mem_rsp.ready`.
- After completion there is at least one IDLE cycle, matching the controller's return to idle.
- A requester must drop `valid` in the cycle after its ready. A valid still high in IDLE is treated as a new request.
- Simultaneous requests in IDLE: `prio` wins; the loser is served next, with no starvation.
- `mem_rsp.ready` and watchdog expiry in the same cycle: the real response wins (data passed through, no error).
- `rst` mid-transaction: immediate return to IDLE and `mem_req.valid`=0. The SRAM controller must be reset together with this block.

## Structure
- `cache_definition` package: existing `cache_to_mem_type`, `mem_to_cache_type`; add `arb_state_type` enum {IDLE, OWN0, OWN1} and `ARB_PORTS=2`.
- Single module, no sub-modules.
- Comb block: request mux and response demux selected by state.
- Seq block: state, `prio`, counter, `timeout_err`, with async reset.

## Test plan
- Single request: req0 read at addr 0x00010, mem_rsp.ready 3 cycles after grant with data 0xBEEF -> grant=01 from next cycle; rsp0.ready=1/data=0xBEEF in the ready cycle; rsp1.ready stays 0; IDLE the following cycle.
- Simultaneous: req0 and req1 valid after reset -> port 0 served first (prio=0); port 1 granted after one IDLE cycle; a third simultaneous pair is then served port 0 first.
- Continuous contention: both valid for 10 transactions -> grants alternate 01,10,01,...; each port gets 5 completions.
- Write forwarding: req1 write, addr 0xFFFFF, data 0x1234 -> mem_req mirrors rw=1, addr, data exactly while grant=10; mem_req.valid=0 in IDLE.
- Watchdog: TIMEOUT_CYCLES=4, mem_rsp.ready held 0 -> rsp0.ready pulse with data 0 on the 4th granted cycle; timeout_err=1 and stays 1; the next request still works.
- Async reset: assert rst mid-OWN1, between clock edges -> grant=00, mem_req.valid=0, timeout_err=0 immediately, without waiting for an edge.
